shift_reg_deserializer: RTL and testbench



---
 rtl/shift_reg_deserializer.sv | 93 +++++++++
 tb/tb_shift_reg_deserializer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_deserializer.sv
// Serial-to-parallel stage: gathers WIDTH bits into a word and hands it out
// through a one-entry valid/ready holding register with upstream backpressure.
module shift_reg_deserializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_word_valid;

  logic             w_last;
  logic             w_bit_acc;
  logic             w_word_acc;
  logic             w_complete;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_fresh;

  assign w_last     = (r_cnt == LAST);
  // Only the completing bit stalls, and only while the held word is not leaving.
  assign bit_ready  = !(w_last && r_word_valid && !word_ready);
  assign w_bit_acc  = bit_valid && bit_ready;
  assign w_word_acc = r_word_valid && word_ready;
  assign w_complete = w_bit_acc && w_last && !frame_sync;

  always_comb begin
    w_shifted = '0;
    w_fresh   = '0;
    if (LSB_FIRST) begin
      w_shifted            = {bit_in, r_sreg[WIDTH-1:1]};
      w_fresh[WIDTH-1]     = bit_in;
    end else begin
      w_shifted            = {r_sreg[WIDTH-2:0], bit_in};
      w_fresh[0]           = bit_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (frame_sync) begin
      if (w_bit_acc) begin
        r_sreg <= w_fresh;
        r_cnt  <= CW'(1);
      end else begin
        r_sreg <= '0;
        r_cnt  <= '0;
      end
    end else if (w_bit_acc) begin
      if (w_last) begin
        r_sreg <= '0;
        r_cnt  <= '0;
      end else begin
        r_sreg <= w_shifted;
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  // A completing word overrides a simultaneous consume, so valid stays high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else if (w_complete) begin
      r_word       <= w_shifted;
      r_word_valid <= 1'b1;
    end else if (w_word_acc) begin
      r_word_valid <= 1'b0;
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_word_valid;
  assign busy       = (r_cnt != '0);

endmodule

// File: tb/tb_shift_reg_deserializer.sv
// Directed bench: MSB-first and LSB-first instances share stimulus; a vector
// table covers the handshake cases, plus streaming and combinational-ready sequences.
module tb_shift_reg_deserializer;

  logic       clock = 1'b0;
  logic       reset, bit_in, bit_valid, frame_sync, word_ready;
  logic       m_bit_ready, m_word_valid, m_busy;
  logic       l_bit_ready, l_word_valid, l_busy;
  logic [3:0] m_word_out, l_word_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  shift_reg_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(m_bit_ready), .frame_sync(frame_sync), .word_out(m_word_out),
    .word_valid(m_word_valid), .word_ready(word_ready), .busy(m_busy)
  );

  shift_reg_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(l_bit_ready), .frame_sync(frame_sync), .word_out(l_word_out),
    .word_valid(l_word_valid), .word_ready(word_ready), .busy(l_busy)
  );

  typedef struct {
    logic       rst, bv, bi, fs, wr;
    logic       wv;
    logic [3:0] wm, wl;
    logic       br, busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic bv, logic bi, logic fs, logic wr,
                              logic wv, logic [3:0] wm, logic [3:0] wl,
                              logic br, logic bsy);
    vec_t v;
    v.rst = rst; v.bv = bv; v.bi = bi; v.fs = fs; v.wr = wr;
    v.wv = wv; v.wm = wm; v.wl = wl; v.br = br; v.busy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic bv, input logic bi,
                       input logic fs, input logic wr);
    reset = rst; bit_valid = bv; bit_in = bi; frame_sync = fs; word_ready = wr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [15:0] pat;
  logic [3:0]  m_exp [4];
  logic [3:0]  l_exp [4];
  int          pulses;

  initial begin
    drive(0, 0, 0, 0, 0);
    // rst bv bi fs wr | wv wm wl br busy  (outputs after the edge, inputs still applied)
    vq.push_back(mk(1,0,0,0,0, 0,4'h0,4'h0,1,0));
    // basic word 1,0,1,1
    vq.push_back(mk(0,1,1,0,1, 0,4'h0,4'h0,1,1));
    vq.push_back(mk(0,1,0,0,1, 0,4'h0,4'h0,1,1));
    vq.push_back(mk(0,1,1,0,1, 0,4'h0,4'h0,1,1));
    vq.push_back(mk(0,1,1,0,1, 1,4'hB,4'hD,1,0));
    vq.push_back(mk(0,0,0,0,1, 0,4'hB,4'hD,1,0));
    // backpressure: 1,0,1,1,0,1,1,0 with word_ready low
    vq.push_back(mk(0,1,1,0,0, 0,4'hB,4'hD,1,1));
    vq.push_back(mk(0,1,0,0,0, 0,4'hB,4'hD,1,1));
    vq.push_back(mk(0,1,1,0,0, 0,4'hB,4'hD,1,1));
    vq.push_back(mk(0,1,1,0,0, 1,4'hB,4'hD,1,0));
    vq.push_back(mk(0,1,0,0,0, 1,4'hB,4'hD,1,1));
    vq.push_back(mk(0,1,1,0,0, 1,4'hB,4'hD,1,1));
    vq.push_back(mk(0,1,1,0,0, 1,4'hB,4'hD,0,1));
    vq.push_back(mk(0,1,0,0,0, 1,4'hB,4'hD,0,1));
    vq.push_back(mk(0,1,0,0,1, 1,4'h6,4'h6,1,0));
    vq.push_back(mk(0,0,0,0,1, 0,4'h6,4'h6,1,0));
    // frame_sync alone after two bits, then 0,1,0,1
    vq.push_back(mk(0,1,1,0,1, 0,4'h6,4'h6,1,1));
    vq.push_back(mk(0,1,1,0,1, 0,4'h6,4'h6,1,1));
    vq.push_back(mk(0,0,0,1,1, 0,4'h6,4'h6,1,0));
    vq.push_back(mk(0,1,0,0,1, 0,4'h6,4'h6,1,1));
    vq.push_back(mk(0,1,1,0,1, 0,4'h6,4'h6,1,1));
    vq.push_back(mk(0,1,0,0,1, 0,4'h6,4'h6,1,1));
    vq.push_back(mk(0,1,1,0,1, 1,4'h5,4'hA,1,0));
    vq.push_back(mk(0,0,0,0,1, 0,4'h5,4'hA,1,0));
    // frame_sync coincident with a bit: 1,0 dropped; 1,1,0,0 kept
    vq.push_back(mk(0,1,1,0,1, 0,4'h5,4'hA,1,1));
    vq.push_back(mk(0,1,0,0,1, 0,4'h5,4'hA,1,1));
    vq.push_back(mk(0,1,1,1,1, 0,4'h5,4'hA,1,1));
    vq.push_back(mk(0,1,1,0,1, 0,4'h5,4'hA,1,1));
    vq.push_back(mk(0,1,0,0,1, 0,4'h5,4'hA,1,1));
    vq.push_back(mk(0,1,0,0,1, 1,4'hC,4'h3,1,0));
    vq.push_back(mk(0,0,0,0,1, 0,4'hC,4'h3,1,0));
    // frame_sync on the would-be completing bit does not complete
    vq.push_back(mk(0,1,0,0,1, 0,4'hC,4'h3,1,1));
    vq.push_back(mk(0,1,0,0,1, 0,4'hC,4'h3,1,1));
    vq.push_back(mk(0,1,0,0,1, 0,4'hC,4'h3,1,1));
    vq.push_back(mk(0,1,1,1,1, 0,4'hC,4'h3,1,1));
    vq.push_back(mk(0,1,0,0,1, 0,4'hC,4'h3,1,1));
    vq.push_back(mk(0,1,1,0,1, 0,4'hC,4'h3,1,1));
    vq.push_back(mk(0,1,0,0,1, 1,4'hA,4'h5,1,0));
    vq.push_back(mk(0,0,0,0,1, 0,4'hA,4'h5,1,0));
    // reset with a held word and a partial word
    vq.push_back(mk(0,1,1,0,0, 0,4'hA,4'h5,1,1));
    vq.push_back(mk(0,1,0,0,0, 0,4'hA,4'h5,1,1));
    vq.push_back(mk(0,1,1,0,0, 0,4'hA,4'h5,1,1));
    vq.push_back(mk(0,1,1,0,0, 1,4'hB,4'hD,1,0));
    vq.push_back(mk(0,1,1,0,0, 1,4'hB,4'hD,1,1));
    vq.push_back(mk(0,1,0,0,0, 1,4'hB,4'hD,1,1));
    vq.push_back(mk(1,1,1,0,0, 0,4'h0,4'h0,1,0));
    vq.push_back(mk(0,1,0,0,1, 0,4'h0,4'h0,1,1));
    vq.push_back(mk(0,1,1,0,1, 0,4'h0,4'h0,1,1));
    vq.push_back(mk(0,1,1,0,1, 0,4'h0,4'h0,1,1));
    vq.push_back(mk(0,1,1,0,1, 1,4'h7,4'hE,1,0));
    vq.push_back(mk(0,0,0,0,1, 0,4'h7,4'hE,1,0));

    step();
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].bv, vq[i].bi, vq[i].fs, vq[i].wr);
      step();
      chk($sformatf("v%0d word_valid", i), 32'(m_word_valid), 32'(vq[i].wv));
      chk($sformatf("v%0d lsb_word_valid", i), 32'(l_word_valid), 32'(vq[i].wv));
      chk($sformatf("v%0d word_out_msb", i), 32'(m_word_out), 32'(vq[i].wm));
      chk($sformatf("v%0d word_out_lsb", i), 32'(l_word_out), 32'(vq[i].wl));
      chk($sformatf("v%0d bit_ready", i), 32'(m_bit_ready), 32'(vq[i].br));
      chk($sformatf("v%0d busy", i), 32'(m_busy), 32'(vq[i].busy));
      chk($sformatf("v%0d lsb_busy", i), 32'(l_busy), 32'(vq[i].busy));
    end

    // Continuous streaming: 16 bits, one word every 4 cycles, never stalled
    pat = 16'hA5C3;
    m_exp[0] = 4'hA; m_exp[1] = 4'h5; m_exp[2] = 4'hC; m_exp[3] = 4'h3;
    l_exp[0] = 4'h5; l_exp[1] = 4'hA; l_exp[2] = 4'h3; l_exp[3] = 4'hC;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, pat[15-i], 0, 1);
      chk($sformatf("stream%0d bit_ready_pre", i), 32'(m_bit_ready), 32'd1);
      step();
      if (m_word_valid) pulses++;
      chk($sformatf("stream%0d word_valid", i), 32'(m_word_valid), 32'((i % 4) == 3));
      if ((i % 4) == 3) begin
        chk($sformatf("stream%0d word_msb", i), 32'(m_word_out), 32'(m_exp[i/4]));
        chk($sformatf("stream%0d word_lsb", i), 32'(l_word_out), 32'(l_exp[i/4]));
      end
    end
    chk("stream word count", 32'(pulses), 32'd4);
    drive(0, 0, 0, 0, 1);
    step();
    chk("stream drained", 32'(m_word_valid), 32'd0);

    // bit_ready follows word_ready combinationally when the completing bit waits
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, (i < 4) ? 1'b1 : 1'b0, 0, 0);
      step();
    end
    chk("stall bit_ready", 32'(m_bit_ready), 32'd0);
    chk("stall word held", 32'(m_word_out), 32'hF);
    word_ready = 1'b1;
    #1;
    chk("comb bit_ready high", 32'(m_bit_ready), 32'd1);
    word_ready = 1'b0;
    #1;
    chk("comb bit_ready low", 32'(m_bit_ready), 32'd0);
    step();
    chk("stall word stable", 32'(m_word_out), 32'hF);
    chk("stall valid stable", 32'(m_word_valid), 32'd1);
    chk("stall busy", 32'(m_busy), 32'd1);
    drive(0, 0, 0, 0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
